// File: rtl/fsm_ctrl_pkg.sv
// rtl/fsm_ctrl_pkg.sv - shared state encoding and width helper for the pattern drive controller
package fsm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  function automatic int count_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/pat_shreg.sv
// rtl/pat_shreg.sv - parallel-load, shift-right pattern register presenting bit 0 serially
module pat_shreg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             q0
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign q0 = sr[0];

endmodule

// File: rtl/pattern_drive_ctrl.sv
// rtl/pattern_drive_ctrl.sv - drives a pattern serially into a sequence detector and records its match output
module pattern_drive_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int LAT   = 1,
  localparam int CW    = count_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  output logic             det_rst_n,
  output logic             w,
  output logic             w_valid,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    match_cnt,
  output logic [WIDTH-1:0] match_map
);

  localparam int IW = $clog2(WIDTH);

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic            last_bit;
  logic            accept;
  logic            q0;
  logic            samp_en;
  logic [IW-1:0]   samp_idx;
  logic            det_q;

  assign last_bit = (idx == IW'(WIDTH - 1));
  assign accept   = (state == IDLE) && start;

  pat_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state == SHIFT),
    .din   (din),
    .q0    (q0)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Abort wins over any same-cycle advance out of LOAD/SHIFT/DRAIN.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = abort ? IDLE : SHIFT;
      SHIFT: begin
        if (abort)         state_nx = IDLE;
        else if (last_bit) state_nx = (LAT == 0) ? DONE : DRAIN;
      end
      DRAIN:   state_nx = abort ? IDLE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A Moore detector answers one cycle late, so the sample slot trails the shift slot.
  if (LAT == 0) begin : g_mealy
    assign samp_en  = (state == SHIFT) && !abort;
    assign samp_idx = idx;
  end else begin : g_moore
    logic          pend;
    logic [IW-1:0] pidx;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pend <= 1'b0;
        pidx <= '0;
      end else begin
        pend <= (state == SHIFT) && !abort;
        pidx <= idx;
      end
    end
    assign samp_en  = pend && !abort;
    assign samp_idx = pidx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      match_cnt <= '0;
      match_map <= '0;
      det_q     <= 1'b0;
    end else begin
      det_q <= (state_nx != LOAD);
      idx   <= (state == SHIFT) ? idx + IW'(1) : '0;
      if (accept) begin
        match_cnt <= '0;
        match_map <= '0;
      end else if (samp_en) begin
        match_map[samp_idx] <= z;
        if (z) match_cnt <= match_cnt + CW'(1);
      end
    end
  end

  assign det_rst_n = det_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign w_valid   = (state == SHIFT);
  assign w         = w_valid & q0;

endmodule

// File: tb/tb_pattern_drive_ctrl.sv
// tb/tb_pattern_drive_ctrl.sv - scoreboard bench running Mealy (LAT=0) and Moore (LAT=1) controllers side by side
module tb_pattern_drive_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [15:0] din;

  logic        det_rst_n0, w0, w_valid0, z0, busy0, done0;
  logic [4:0]  match_cnt0;
  logic [15:0] match_map0;
  logic        det_rst_n1, w1, w_valid1, z1, busy1, done1;
  logic [4:0]  match_cnt1;
  logic [15:0] match_map1;

  int          errors = 0;
  int          checks = 0;
  int          mode = 1;
  logic [15:0] zvec = '0;

  typedef struct {
    logic [15:0] map;
    int          cnt;
    int          cycles;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  pattern_drive_ctrl #(.WIDTH(16), .LAT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .din(din),
    .det_rst_n(det_rst_n0), .w(w0), .w_valid(w_valid0), .z(z0),
    .busy(busy0), .done(done0), .match_cnt(match_cnt0), .match_map(match_map0)
  );

  pattern_drive_ctrl #(.WIDTH(16), .LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .din(din),
    .det_rst_n(det_rst_n1), .w(w1), .w_valid(w_valid1), .z(z1),
    .busy(busy1), .done(done1), .match_cnt(match_cnt1), .match_map(match_map1)
  );

  // "101" overlapping detectors: Mealy on dut0, Moore on dut1
  logic [1:0] mealy_h, mealy_n;
  logic [2:0] moore_h;
  logic [1:0] moore_n;
  logic       mealy_z, moore_z;

  always_ff @(posedge clk or negedge det_rst_n0) begin
    if (!det_rst_n0) begin
      mealy_h <= '0;
      mealy_n <= '0;
    end else begin
      mealy_h <= {mealy_h[0], w0};
      if (mealy_n != 2'd2) mealy_n <= mealy_n + 2'd1;
    end
  end
  assign mealy_z = (mealy_n == 2'd2) && (mealy_h == 2'b10) && w0;

  always_ff @(posedge clk or negedge det_rst_n1) begin
    if (!det_rst_n1) begin
      moore_h <= '0;
      moore_n <= '0;
    end else begin
      moore_h <= {moore_h[1:0], w1};
      if (moore_n != 2'd3) moore_n <= moore_n + 2'd1;
    end
  end
  assign moore_z = (moore_n == 2'd3) && (moore_h == 3'b101);

  logic [3:0] k0 = '0, k1 = '0;
  logic       wq1 = 1'b0, zq1 = 1'b0;
  always_ff @(posedge clk) begin
    k0  <= w_valid0 ? k0 + 4'd1 : 4'd0;
    k1  <= w_valid1 ? k1 + 4'd1 : 4'd0;
    wq1 <= w1;
    zq1 <= w_valid1 & zvec[k1];
  end

  always_comb begin
    case (mode)
      0:       z0 = mealy_z;
      1:       z0 = w0;
      2:       z0 = 1'b1;
      default: z0 = w_valid0 & zvec[k0];
    endcase
    case (mode)
      0:       z1 = moore_z;
      1:       z1 = wq1;
      2:       z1 = 1'b1;
      default: z1 = zq1;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] det_ref(input logic [15:0] p);
    logic [15:0] r;
    r = '0;
    for (int k = 2; k < 16; k++) r[k] = p[k-2] & ~p[k-1] & p[k];
    return r;
  endfunction

  // Monitor: busy/valid cycle counts per run, scoreboard pop on each done pulse
  int bc0 = 0, vc0 = 0, bc1 = 0, vc1 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!busy0) begin bc0 = 0; vc0 = 0; end
    else begin bc0++; if (w_valid0) vc0++; end
    if (!busy1) begin bc1 = 0; vc1 = 0; end
    else begin bc1++; if (w_valid1) vc1++; end
    if (done0) begin
      if (q0.size() == 0) chk("unexpected_done0", 1, 0);
      else begin
        e = q0.pop_front();
        chk("map0", match_map0, e.map);
        chk("cnt0", match_cnt0, e.cnt);
        chk("cycles0", bc0, e.cycles);
        chk("nvalid0", vc0, 16);
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("unexpected_done1", 1, 0);
      else begin
        e = q1.pop_front();
        chk("map1", match_map1, e.map);
        chk("cnt1", match_cnt1, e.cnt);
        chk("cycles1", bc1, e.cycles);
        chk("nvalid1", vc1, 16);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic run(input int m, input logic [15:0] p, input logic [15:0] zv);
    exp_t e;
    mode = m;
    zvec = zv;
    din  = p;
    case (m)
      0:       e.map = det_ref(p);
      1:       e.map = p;
      2:       e.map = 16'hFFFF;
      default: e.map = zv;
    endcase
    e.cnt = $countones(e.map);
    e.cycles = 18;
    q0.push_back(e);
    e.cycles = 19;
    q1.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    din = 16'($urandom);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs0", {busy0, done0, w0, w_valid0, det_rst_n0, match_cnt0, match_map0}, 0);
    chk("rst_outs1", {busy1, done1, w1, w_valid1, det_rst_n1, match_cnt1, match_map1}, 0);
    @(negedge clk); reset = 1'b1; #1;
    chk("rst_rel_det0", det_rst_n0, 0);
    @(posedge clk); #1;
    chk("rst_rel_det_edge", {det_rst_n0, det_rst_n1}, 2'b11);

    run(1, 16'hA5A5, 16'h0);
    run(2, 16'hFFFF, 16'h0);
    run(0, 16'b0101_0111_0111_0010, 16'h0);
    run(0, 16'hFFFF, 16'h0);
    for (int i = 0; i < 12; i++) run(int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));

    // abort in SHIFT bit 5 with z held high
    mode = 2; din = 16'hFFFF;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_in_shift", {w_valid0, w_valid1}, 2'b11);
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    chk("abort_idle", {busy0, busy1, done0, done1}, 0);
    chk("abort_cnt0", match_cnt0, 5);
    chk("abort_cnt1", match_cnt1, 4);
    chk("abort_map0", match_map0, 16'h001F);
    chk("abort_map1", match_map1, 16'h000F);
    repeat (25) @(posedge clk);
    #1;

    // start during SHIFT is ignored, then reset mid-run
    mode = 1; din = 16'hFFFF;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    chk("start_ignored_shift", {w_valid0, w_valid1}, 2'b11);
    chk("start_ignored_cnt0", match_cnt0, 4);
    chk("start_ignored_cnt1", match_cnt1, 3);
    reset = 1'b0; #1;
    chk("midrst_outs0", {busy0, done0, w0, w_valid0, det_rst_n0, match_cnt0, match_map0}, 0);
    chk("midrst_outs1", {busy1, done1, w1, w_valid1, det_rst_n1, match_cnt1, match_map1}, 0);
    @(negedge clk); reset = 1'b1; #1;
    chk("midrst_rel_det", {det_rst_n0, det_rst_n1}, 0);
    @(posedge clk); #1;
    chk("midrst_det_edge", {det_rst_n0, det_rst_n1}, 2'b11);

    run(3, 16'h1234, 16'hBEEF);
    run(1, 16'h8001, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("queues_empty", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
